// File: rtl/mmio_port_responder.sv
// Memory-mapped responder for the core's data bus: output port, synchronized input port,
// down-counting timer, sticky status flags and a registered interrupt line.
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         ReadData,
    output logic                Hit,
    output logic [31:0]         PortOut,
    output logic                Irq
);
    localparam logic [2:0] OffPortOut  = 3'd0;
    localparam logic [2:0] OffPortIn   = 3'd1;
    localparam logic [2:0] OffStatus   = 3'd2;
    localparam logic [2:0] OffTmrLoad  = 3'd3;
    localparam logic [2:0] OffTmrCount = 3'd4;
    localparam logic [2:0] OffControl  = 3'd5;

    logic [2:0]          offset;
    logic                wrEn;
    logic                wrPortOut, wrStatus, wrTmrLoad, wrControl;
    logic [IN_WIDTH-1:0] sync1, sync2, sync3;
    logic                inChanged, tmrExpired;
    logic [31:0]         tmrLoad, tmrCount;
    logic [3:0]          control;
    logic                tmrStep, tmrWrap;
    logic [31:0]         readMux;

    // Counting saturates at zero; expiry is handled separately on the zero cycle.
    function automatic logic [31:0] satDec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

    assign Hit       = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00);
    assign offset    = Address[4:2];
    assign wrEn      = MemWrite && Hit;
    assign wrPortOut = wrEn && (offset == OffPortOut);
    assign wrStatus  = wrEn && (offset == OffStatus);
    assign wrTmrLoad = wrEn && (offset == OffTmrLoad);
    assign wrControl = wrEn && (offset == OffControl);

    // A TMR_LOAD write pre-empts the whole timer evaluation for that edge.
    assign tmrStep = control[0] && !wrTmrLoad;
    assign tmrWrap = tmrStep && (tmrCount == 32'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1      <= '0;
            sync2      <= '0;
            sync3      <= '0;
            inChanged  <= 1'b0;
            tmrExpired <= 1'b0;
            PortOut    <= '0;
            tmrLoad    <= '0;
            tmrCount   <= '0;
            control    <= '0;
            Irq        <= 1'b0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
            sync3 <= sync2;

            // Set events win over a simultaneous write-one-to-clear.
            inChanged  <= (inChanged & ~(wrStatus & WriteData[0])) | (sync2 != sync3);
            tmrExpired <= (tmrExpired & ~(wrStatus & WriteData[1])) | tmrWrap;

            if (wrPortOut)
                PortOut <= WriteData;

            if (wrTmrLoad) begin
                tmrLoad  <= WriteData;
                tmrCount <= WriteData;
            end else if (tmrStep) begin
                tmrCount <= (tmrWrap && control[1]) ? tmrLoad : satDec(tmrCount);
            end

            // Software CONTROL write overrides the one-shot self-disable.
            if (wrControl)
                control <= WriteData[3:0];
            else if (tmrWrap && !control[1])
                control[0] <= 1'b0;

            Irq <= (inChanged & control[2]) | (tmrExpired & control[3]);
        end
    end

    always_comb begin
        readMux = '0;
        case (offset)
            OffPortOut:  readMux = PortOut;
            OffPortIn:   readMux = 32'(sync2);
            OffStatus:   readMux = {30'd0, tmrExpired, inChanged};
            OffTmrLoad:  readMux = tmrLoad;
            OffTmrCount: readMux = tmrCount;
            OffControl:  readMux = {28'd0, control};
            default:     readMux = '0;
        endcase
    end

    assign ReadData = (MemRead && Hit) ? readMux : 32'd0;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: directed register-map scenarios plus randomized bus
// traffic checked against a register-level reference model.
module tb_mmio_port_responder;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          INW  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     Address;
    logic [31:0]     WriteData;
    logic            MemWrite;
    logic            MemRead;
    logic [INW-1:0]  PortIn;
    logic [31:0]     ReadData;
    logic            Hit;
    logic [31:0]     PortOut;
    logic            Irq;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model state, kept as the software-visible registers.
    logic [31:0]    mPortOut, mLoad, mCount;
    logic [3:0]     mCtrl;
    logic           mInCh, mExp, mIrq;
    logic [INW-1:0] pinHist [3];  // PortIn captured at the last three edges, newest first

    mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(INW)) dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
        .ReadData(ReadData), .Hit(Hit), .PortOut(PortOut), .Irq(Irq)
    );

    always #5 clk = ~clk;

    function automatic logic inWindow(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32) && (a % 4 == 0);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        if (!inWindow(a)) return 32'd0;
        case ((a - BASE) / 4)
            0: return mPortOut;
            1: return {24'd0, pinHist[1]};
            2: return {30'd0, mExp, mInCh};
            3: return mLoad;
            4: return mCount;
            5: return {28'd0, mCtrl};
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock edge, updating the model from the bus values present before it.
    task automatic tick();
        logic [31:0]    nOut, nLoad, nCount;
        logic [3:0]     nCtrl;
        logic           nInCh, nExp, nIrq, wr, rstNow;
        logic [INW-1:0] pin;
        int             idx;
        wr     = MemWrite && inWindow(Address);
        idx    = int'((Address - BASE) / 4);
        rstNow = reset;
        pin    = PortIn;
        nOut   = (wr && idx == 0) ? WriteData : mPortOut;
        nInCh  = (mInCh && !(wr && idx == 2 && WriteData[0])) || (pinHist[1] != pinHist[2]);
        nExp   = mExp && !(wr && idx == 2 && WriteData[1]);
        nLoad  = mLoad;
        nCount = mCount;
        nCtrl  = mCtrl;
        if (wr && idx == 3) begin
            nLoad  = WriteData;
            nCount = WriteData;
        end else if (mCtrl[0]) begin
            if (mCount != 0) nCount = mCount - 1;
            else begin
                nExp = 1'b1;
                if (mCtrl[1]) nCount = mLoad;
                else nCtrl[0] = 1'b0;
            end
        end
        if (wr && idx == 5) nCtrl = WriteData[3:0];
        nIrq = (mInCh && mCtrl[2]) || (mExp && mCtrl[3]);
        @(posedge clk);
        if (!rstNow) begin
            mPortOut = 0; mLoad = 0; mCount = 0; mCtrl = 0;
            mInCh = 0; mExp = 0; mIrq = 0;
            pinHist[0] = 0; pinHist[1] = 0; pinHist[2] = 0;
        end else begin
            mPortOut = nOut; mLoad = nLoad; mCount = nCount; mCtrl = nCtrl;
            mInCh = nInCh; mExp = nExp; mIrq = nIrq;
            pinHist[2] = pinHist[1]; pinHist[1] = pinHist[0]; pinHist[0] = pin;
        end
        #1;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        Address = a; MemRead = 1'b1; MemWrite = 1'b0;
        #1;
        d = ReadData;
        MemRead = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        nChecks++; if (PortOut !== 32'd0) $display("FAIL reset_portout: got %h want 0", PortOut); else nPass++;
        nChecks++; if (Irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", Irq); else nPass++;
        busRead(BASE + 32'h14, rd);
        nChecks++; if (rd !== 32'd0) $display("FAIL reset_control: got %h want 0", rd); else nPass++;
        busRead(BASE + 32'h10, rd);
        nChecks++; if (rd !== 32'd0) $display("FAIL reset_count: got %h want 0", rd); else nPass++;
    endtask

    task automatic test_port_out();
        logic [31:0] rd;
        busWrite(BASE, 32'hDEAD_BEEF);
        nChecks++; if (PortOut !== 32'hDEAD_BEEF) $display("FAIL portout_write: got %h want deadbeef", PortOut); else nPass++;
        Address = BASE; MemRead = 1'b1; #1;
        nChecks++; if (Hit !== 1'b1) $display("FAIL hit_base: got %b want 1", Hit); else nPass++;
        nChecks++; if (ReadData !== 32'hDEAD_BEEF) $display("FAIL portout_read: got %h want deadbeef", ReadData); else nPass++;
        MemRead = 1'b0; #1;
        nChecks++; if (ReadData !== 32'd0) $display("FAIL read_no_strobe: got %h want 0", ReadData); else nPass++;
        Address = BASE + 32'h2; WriteData = 32'h1234_5678; MemWrite = 1'b1; #1;
        nChecks++; if (Hit !== 1'b0) $display("FAIL hit_misaligned: got %b want 0", Hit); else nPass++;
        tick();
        MemWrite = 1'b0;
        nChecks++; if (PortOut !== 32'hDEAD_BEEF) $display("FAIL misaligned_write: got %h want deadbeef", PortOut); else nPass++;
        Address = BASE + 32'h20; MemRead = 1'b1; #1;
        nChecks++; if (Hit !== 1'b0) $display("FAIL hit_outside: got %b want 0", Hit); else nPass++;
        nChecks++; if (ReadData !== 32'd0) $display("FAIL read_outside: got %h want 0", ReadData); else nPass++;
        MemRead = 1'b0;
    endtask

    task automatic test_port_in();
        logic [31:0] rd;
        busWrite(BASE + 32'h14, 32'h4);
        PortIn = 8'h5A;
        tick();
        busRead(BASE + 32'h4, rd);
        nChecks++; if (rd !== 32'h0) $display("FAIL portin_edge1: got %h want 0", rd); else nPass++;
        tick();
        busRead(BASE + 32'h4, rd);
        nChecks++; if (rd !== 32'h5A) $display("FAIL portin_edge2: got %h want 5a", rd); else nPass++;
        busRead(BASE + 32'h8, rd);
        nChecks++; if (rd !== 32'h0) $display("FAIL inchg_edge2: got %h want 0", rd); else nPass++;
        tick();
        busRead(BASE + 32'h8, rd);
        nChecks++; if (rd !== 32'h1) $display("FAIL inchg_edge3: got %h want 1", rd); else nPass++;
        nChecks++; if (Irq !== 1'b0) $display("FAIL irq_edge3: got %b want 0", Irq); else nPass++;
        tick();
        nChecks++; if (Irq !== 1'b1) $display("FAIL irq_edge4: got %b want 1", Irq); else nPass++;
        busWrite(BASE + 32'h8, 32'h1);
        busRead(BASE + 32'h8, rd);
        nChecks++; if (rd !== 32'h0) $display("FAIL inchg_w1c: got %h want 0", rd); else nPass++;
        nChecks++; if (Irq !== 1'b1) $display("FAIL irq_lag: got %b want 1", Irq); else nPass++;
        tick();
        nChecks++; if (Irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", Irq); else nPass++;
        busWrite(BASE + 32'h14, 32'h0);
    endtask

    task automatic test_timer_autoreload();
        logic [31:0] rd;
        logic [31:0] seq [3] = '{32'd2, 32'd1, 32'd0};
        busWrite(BASE + 32'hC, 32'd3);
        busWrite(BASE + 32'h14, 32'h3);
        busRead(BASE + 32'h10, rd);
        nChecks++; if (rd !== 32'd3) $display("FAIL tmr_start: got %0d want 3", rd); else nPass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            busRead(BASE + 32'h10, rd);
            nChecks++; if (rd !== seq[i]) $display("FAIL tmr_count%0d: got %0d want %0d", i, rd, seq[i]); else nPass++;
        end
        tick();
        busRead(BASE + 32'h10, rd);
        nChecks++; if (rd !== 32'd3) $display("FAIL tmr_reload: got %0d want 3", rd); else nPass++;
        busRead(BASE + 32'h8, rd);
        nChecks++; if (rd !== 32'h2) $display("FAIL tmr_expired: got %h want 2", rd); else nPass++;
        busWrite(BASE + 32'h8, 32'h2);
        busRead(BASE + 32'h8, rd);
        nChecks++; if (rd !== 32'h0) $display("FAIL tmr_w1c: got %h want 0", rd); else nPass++;
        tick();
        tick();
        tick();
        busRead(BASE + 32'h10, rd);
        nChecks++; if (rd !== 32'd3) $display("FAIL tmr_period: got %0d want 3", rd); else nPass++;
        busRead(BASE + 32'h8, rd);
        nChecks++; if (rd !== 32'h2) $display("FAIL tmr_expired2: got %h want 2", rd); else nPass++;
        busWrite(BASE + 32'h14, 32'h0);
        busWrite(BASE + 32'h8, 32'h3);
    endtask

    task automatic test_timer_oneshot();
        logic [31:0] rd;
        busWrite(BASE + 32'hC, 32'd2);
        busWrite(BASE + 32'h14, 32'h1);
        busRead(BASE + 32'h10, rd);
        nChecks++; if (rd !== 32'd2) $display("FAIL os_start: got %0d want 2", rd); else nPass++;
        tick();
        tick();
        busRead(BASE + 32'h10, rd);
        nChecks++; if (rd !== 32'd0) $display("FAIL os_zero: got %0d want 0", rd); else nPass++;
        busWrite(BASE + 32'h8, 32'h2);
        busRead(BASE + 32'h8, rd);
        nChecks++; if (rd !== 32'h2) $display("FAIL os_set_wins: got %h want 2", rd); else nPass++;
        busRead(BASE + 32'h14, rd);
        nChecks++; if (rd !== 32'h0) $display("FAIL os_ctrl_clear: got %h want 0", rd); else nPass++;
        tick();
        busRead(BASE + 32'h10, rd);
        nChecks++; if (rd !== 32'd0) $display("FAIL os_hold: got %0d want 0", rd); else nPass++;
        busWrite(BASE + 32'h8, 32'h3);
    endtask

    task automatic test_reset_midcount();
        logic [31:0] rd;
        PortIn = 8'hA5;
        busWrite(BASE, 32'h55);
        busWrite(BASE + 32'hC, 32'd9);
        busWrite(BASE + 32'h14, 32'h3);
        for (int i = 0; i < 4; i++) tick();
        busRead(BASE + 32'h10, rd);
        nChecks++; if (rd !== 32'd5) $display("FAIL mid_count5: got %0d want 5", rd); else nPass++;
        busRead(BASE + 32'h8, rd);
        nChecks++; if (rd !== 32'h1) $display("FAIL mid_status: got %h want 1", rd); else nPass++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        busRead(BASE + 32'h10, rd);
        nChecks++; if (rd !== 32'd0) $display("FAIL rst_count: got %0d want 0", rd); else nPass++;
        busRead(BASE + 32'h14, rd);
        nChecks++; if (rd !== 32'd0) $display("FAIL rst_control: got %h want 0", rd); else nPass++;
        busRead(BASE + 32'h8, rd);
        nChecks++; if (rd !== 32'd0) $display("FAIL rst_status: got %h want 0", rd); else nPass++;
        nChecks++; if (PortOut !== 32'd0) $display("FAIL rst_portout: got %h want 0", PortOut); else nPass++;
        tick();
        tick();
        tick();
        busRead(BASE + 32'h10, rd);
        nChecks++; if (rd !== 32'd0) $display("FAIL rst_no_resume: got %0d want 0", rd); else nPass++;
    endtask

    task automatic test_random_traffic();
        logic [31:0] addr, want;
        int          kind, off;
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 15);
            off  = $urandom_range(0, 7);
            if (kind == 0)      addr = BASE + 32'h20 + 32'(off * 4);
            else if (kind == 1) addr = BASE + 32'(off * 4) + 32'($urandom_range(1, 3));
            else if (kind == 2) addr = BASE - 32'h20 + 32'(off * 4);
            else                addr = BASE + 32'(off * 4);
            Address   = addr;
            MemWrite  = ($urandom_range(0, 2) == 0);
            MemRead   = $urandom_range(0, 1) == 1;
            WriteData = (off == 3) ? 32'($urandom_range(0, 6)) : $urandom;
            if ($urandom_range(0, 7) == 0) PortIn = INW'($urandom);
            reset = ($urandom_range(0, 99) != 0);
            #1;
            nChecks++; if (Hit !== inWindow(addr)) $display("FAIL rnd_hit %0d: addr %h got %b want %b", i, addr, Hit, inWindow(addr)); else nPass++;
            want = MemRead ? modelRead(addr) : 32'd0;
            nChecks++; if (ReadData !== want) $display("FAIL rnd_read %0d: addr %h got %h want %h", i, addr, ReadData, want); else nPass++;
            tick();
            nChecks++; if (PortOut !== mPortOut) $display("FAIL rnd_portout %0d: got %h want %h", i, PortOut, mPortOut); else nPass++;
            nChecks++; if (Irq !== mIrq) $display("FAIL rnd_irq %0d: got %b want %b", i, Irq, mIrq); else nPass++;
        end
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        reset    = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0; Address = 32'd0; WriteData = 32'd0;
        MemWrite = 1'b0; MemRead = 1'b0; PortIn = '0;
        test_reset();
        test_port_out();
        test_port_in();
        test_timer_autoreload();
        test_timer_oneshot();
        test_reset_midcount();
        test_random_traffic();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor data-memory bus: the target end of the load/store interface that the unicycle core drives.
- Decodes the core's Address/MemRead/MemWrite/WriteData and returns ReadData the same cycle, as a single-cycle core requires.
- Owns the PortOut output register, a synchronized and change-detected PortIn, and a down-counting timer, with sticky status flags and an interrupt line.
- Top level uses Hit to choose between this block's ReadData and DataMemory's.

Parameters:
BASE_ADDR, 32'h1000_0000, byte base of the 32-byte register window; bits [4:0] must be 0.
IN_WIDTH, 8, width of PortIn.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset.
Address  input  32  byte address from ALU result.
WriteData  input  32  store data (rt register).
MemWrite  input  1  store strobe, sampled at clk edge.
MemRead  input  1  load strobe.
PortIn  input  IN_WIDTH  asynchronous external input.
ReadData  output  32  load data, combinational.
Hit  output  1  Address is in the window and word-aligned, combinational.
PortOut  output  32  registered output port.
Irq  output  1  registered OR of enabled sticky flags.

Behaviour:
- Decode:
  - Hit = (Address[31:5]==BASE_ADDR[31:5]) && (Address[1:0]==0).
  - Offset = Address[4:2].
  - Writes take effect at the clk edge when MemWrite && Hit.
  - ReadData = selected register when MemRead && Hit, else 32'h0.
- Register map (offset, access):
  - 0x00 PORT_OUT, RW, 32 bits, drives PortOut.
  - 0x04 PORT_IN, RO, zero-extended sync2 value.
  - 0x08 STATUS, RO/W1C: bit0 in_changed, bit1 tmr_expired.
  - 0x0C TMR_LOAD, RW, 32 bits; a write also copies WriteData into TMR_COUNT.
  - 0x10 TMR_COUNT, RO.
  - 0x14 CONTROL, RW, bits[3:0]: b0 tmr_en, b1 autoreload, b2 ie_in, b3 ie_tmr; bits[31:4] read 0.
  - 0x18 and 0x1C: read 0, writes ignored.
  - Writes to RO offsets are ignored.
- Reset (reset==0 at an edge): every register, synchronizer flop, flag and Irq goes to 0. Reset asserted mid-count aborts the timer; the count does not resume.
- Input synchronizer: three-flop chain sync1 <- PortIn, sync2 <- sync1, sync3 <- sync2.
  - in_changed <= in_changed | (sync2 != sync3) at each edge.
  - A PortIn change before edge 1 sets in_changed after edge 3.
  - PORT_IN reads show the new value after edge 2.
  - If PortIn is nonzero while reset is held, in_changed sets after release. This is intended.
- Timer, evaluated each edge with tmr_en==1 and no TMR_LOAD write that cycle:
  - If TMR_COUNT != 0, TMR_COUNT <= TMR_COUNT - 1.
  - If TMR_COUNT == 0: tmr_expired <= 1.
    - autoreload==1: TMR_COUNT <= TMR_LOAD.
    - autoreload==0: TMR_COUNT stays 0 and tmr_en <= 0 (hardware clears CONTROL.b0).
  - Period is TMR_LOAD+1 cycles.
  - A CONTROL write that sets tmr_en takes effect from the next edge.
  - A TMR_LOAD write in the same cycle as the timer update wins over the decrement.
  - A CONTROL write in the same cycle as the hardware tmr_en clear wins over the clear.
  - No overflow: counting stops at 0.
- W1C: writing STATUS with bit n=1 clears flag n. If a set event and a clear happen in the same cycle, set wins.
- Irq <= (in_changed & ie_in) | (tmr_expired & ie_tmr). Irq is registered, so it lags a flag by one cycle.
- Simultaneous MemRead and MemWrite on the same offset: ReadData shows the pre-edge value.

Test Plan:
1. Reset low 2 cycles, then high → PortOut=0, Irq=0; reading 0x1000_0014 gives 0, 0x1000_0010 gives 0.
2. Write 32'hDEAD_BEEF to 0x1000_0000, then read it → PortOut=DEAD_BEEF after that edge; ReadData=DEAD_BEEF; Hit=1. Address 0x1000_0002 → Hit=0, no write. Address 0x1000_0020 → Hit=0, ReadData=0.
3. PortIn 0x00→0x5A before edge 1 → PORT_IN reads 0x5A after edge 2; STATUS bit0 after edge 3; with ie_in=1, Irq=1 after edge 4. Write 0x1 to STATUS → bit0=0; Irq=0 one edge later.
4. TMR_LOAD=3, then CONTROL=0x3 → after successive edges TMR_COUNT=3,2,1,0; on the next edge tmr_expired=1 and TMR_COUNT=3; repeats every 4 cycles.
5. TMR_LOAD=2, CONTROL=0x1 (one-shot) → counts 2,1,0; on the next edge tmr_expired=1, CONTROL reads 0x0, TMR_COUNT holds 0. A W1C of bit1 on the same edge as expiry leaves bit1=1.
6. Timer running at count 5, reset pulsed low one cycle → TMR_COUNT=0, CONTROL=0, STATUS=0, PortOut=0; no further counting.
